// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle rasteriser: FSM state encoding,
// default panel geometry and the clip-to-panel minimum helper.
package draw_pkg;

    localparam int unsigned DEF_LCD_WIDTH  = 32'd240;
    localparam int unsigned DEF_LCD_HEIGHT = 32'd320;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } draw_state_e;

    // Callers zero-extend into 32 bits so one helper serves both axes.
    function automatic logic [31:0] clip_min(input logic [31:0] a, input logic [31:0] b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/rect_draw_engine_if.sv
// Command and pixel-port bundle of the rectangle rasteriser; the application
// side uses the master modport, the engine the slave modport.
interface rect_draw_engine_if #(
    parameter int unsigned X_WIDTH     = 8,
    parameter int unsigned Y_WIDTH     = 9,
    parameter int unsigned COLOR_WIDTH = 16
);
    logic                   draw;
    logic                   abort;
    logic [X_WIDTH-1:0]     xOrigin;
    logic [Y_WIDTH-1:0]     yOrigin;
    logic [X_WIDTH-1:0]     width;
    logic [Y_WIDTH-1:0]     height;
    logic                   outline;
    logic [COLOR_WIDTH-1:0] pixelData;
    logic                   pixelReady;
    logic                   ready;
    logic                   done;
    logic                   pixelWrite;
    logic [X_WIDTH-1:0]     xAddr;
    logic [Y_WIDTH-1:0]     yAddr;
    logic [COLOR_WIDTH-1:0] pixelOut;

    modport master (
        output draw, abort, xOrigin, yOrigin, width, height, outline, pixelData, pixelReady,
        input  ready, done, pixelWrite, xAddr, yAddr, pixelOut
    );

    modport slave (
        input  draw, abort, xOrigin, yOrigin, width, height, outline, pixelData, pixelReady,
        output ready, done, pixelWrite, xAddr, yAddr, pixelOut
    );

endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle command to the panel: last column/row
// actually drawn and a flag for commands that cover no on-screen pixel.
module rect_clip
    import draw_pkg::*;
#(
    parameter int unsigned X_WIDTH    = 8,
    parameter int unsigned Y_WIDTH    = 9,
    parameter int unsigned LCD_WIDTH  = DEF_LCD_WIDTH,
    parameter int unsigned LCD_HEIGHT = DEF_LCD_HEIGHT
) (
    input  logic [X_WIDTH-1:0] x_origin,
    input  logic [Y_WIDTH-1:0] y_origin,
    input  logic [X_WIDTH-1:0] width,
    input  logic [Y_WIDTH-1:0] height,
    output logic [X_WIDTH-1:0] x_end,
    output logic [Y_WIDTH-1:0] y_end,
    output logic               empty
);

    logic [X_WIDTH:0] x_last_s;
    logic [Y_WIDTH:0] y_last_s;

    // One extra bit keeps origin+size-1 from wrapping before the clip.
    always_comb begin
        x_last_s = {1'b0, x_origin} + {1'b0, width} - (X_WIDTH+1)'(1);
        y_last_s = {1'b0, y_origin} + {1'b0, height} - (Y_WIDTH+1)'(1);
        x_end    = X_WIDTH'(clip_min(32'(x_last_s), LCD_WIDTH - 32'd1));
        y_end    = Y_WIDTH'(clip_min(32'(y_last_s), LCD_HEIGHT - 32'd1));
        empty    = (width == {X_WIDTH{1'b0}}) || (height == {Y_WIDTH{1'b0}}) ||
                   (32'(x_origin) >= LCD_WIDTH) || (32'(y_origin) >= LCD_HEIGHT);
    end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: one command in, one pixel-write handshake per covered
// pixel out. Outline (border-only) mode exists only when DRAW_OUTLINE_EN is defined.
module rect_draw_engine
    import draw_pkg::*;
#(
    parameter int unsigned X_WIDTH     = 8,
    parameter int unsigned Y_WIDTH     = 9,
    parameter int unsigned COLOR_WIDTH = 16,
    parameter int unsigned LCD_WIDTH   = DEF_LCD_WIDTH,
    parameter int unsigned LCD_HEIGHT  = DEF_LCD_HEIGHT
) (
    input  logic              clock,
    input  logic              reset,
    rect_draw_engine_if.slave bus
);

    draw_state_e            state_q, state_d;
    logic                   setup_phase_q, setup_phase_d;
    logic [X_WIDTH-1:0]     x_origin_q, x_origin_d;
    logic [Y_WIDTH-1:0]     y_origin_q, y_origin_d;
    logic [X_WIDTH-1:0]     width_q, width_d;
    logic [Y_WIDTH-1:0]     height_q, height_d;
    logic [X_WIDTH-1:0]     x_end_q, x_end_d;
    logic [Y_WIDTH-1:0]     y_end_q, y_end_d;
    logic                   empty_q, empty_d;
    logic [X_WIDTH-1:0]     x_q, x_d;
    logic [Y_WIDTH-1:0]     y_q, y_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   abort_seen_q, abort_seen_d;
    logic                   pixel_write_q, pixel_write_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;

    logic [X_WIDTH-1:0]     clip_x_end_s;
    logic [Y_WIDTH-1:0]     clip_y_end_s;
    logic                   clip_empty_s;
    logic                   skip_s;

    rect_clip #(
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .LCD_WIDTH  (LCD_WIDTH),
        .LCD_HEIGHT (LCD_HEIGHT)
    ) u_clip (
        .x_origin (x_origin_q),
        .y_origin (y_origin_q),
        .width    (width_q),
        .height   (height_q),
        .x_end    (clip_x_end_s),
        .y_end    (clip_y_end_s),
        .empty    (clip_empty_s)
    );

`ifdef DRAW_OUTLINE_EN
    logic outline_q, outline_d;

    // Outline flag is part of the captured command.
    always_comb begin
        if ((state_q == ST_IDLE) && bus.draw) begin
            outline_d = bus.outline;
        end else begin
            outline_d = outline_q;
        end
    end

    // Outline flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            outline_q <= 1'b0;
        end else begin
            outline_q <= outline_d;
        end
    end

    // Interior rows of an outline jump from the left edge straight to the right edge.
    assign skip_s = outline_q && (x_q == x_origin_q) &&
                    (y_q != y_origin_q) && (y_q != y_end_q);
`else
    logic unused_outline_s;
    assign unused_outline_s = bus.outline;
    assign skip_s           = 1'b0;
`endif

    // Next-state and datapath: capture, two-cycle setup, write/step scan, done pulse.
    always_comb begin
        state_d       = state_q;
        setup_phase_d = setup_phase_q;
        x_origin_d    = x_origin_q;
        y_origin_d    = y_origin_q;
        width_d       = width_q;
        height_d      = height_q;
        x_end_d       = x_end_q;
        y_end_d       = y_end_q;
        empty_d       = empty_q;
        x_d           = x_q;
        y_d           = y_q;
        color_d       = color_q;
        pixel_write_d = pixel_write_q;
        ready_d       = ready_q;
        done_d        = 1'b0;
        abort_seen_d  = (state_q != ST_IDLE) ? (abort_seen_q | bus.abort) : abort_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.draw) begin
                    x_origin_d    = bus.xOrigin;
                    y_origin_d    = bus.yOrigin;
                    width_d       = bus.width;
                    height_d      = bus.height;
                    color_d       = bus.pixelData;
                    abort_seen_d  = 1'b0;
                    setup_phase_d = 1'b0;
                    ready_d       = 1'b0;
                    state_d       = ST_SETUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                // First cycle registers the clip result, second cycle acts on it.
                if (!setup_phase_q) begin
                    x_end_d       = clip_x_end_s;
                    y_end_d       = clip_y_end_s;
                    empty_d       = clip_empty_s;
                    setup_phase_d = 1'b1;
                end else begin
                    setup_phase_d = 1'b0;
                    if (empty_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        x_d           = x_origin_q;
                        y_d           = y_origin_q;
                        pixel_write_d = 1'b1;
                        state_d       = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.pixelReady) begin
                    pixel_write_d = 1'b0;
                    state_d       = ST_STEP;
                end else begin
                    pixel_write_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (abort_seen_q || bus.abort) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (x_q < x_end_q) begin
                    x_d           = skip_s ? x_end_q : (x_q + X_WIDTH'(1));
                    pixel_write_d = 1'b1;
                    state_d       = ST_WRITE;
                end else if (y_q < y_end_q) begin
                    x_d           = x_origin_q;
                    y_d           = y_q + Y_WIDTH'(1);
                    pixel_write_d = 1'b1;
                    state_d       = ST_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                pixel_write_d = 1'b0;
                ready_d       = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            setup_phase_q <= 1'b0;
            x_origin_q    <= {X_WIDTH{1'b0}};
            y_origin_q    <= {Y_WIDTH{1'b0}};
            width_q       <= {X_WIDTH{1'b0}};
            height_q      <= {Y_WIDTH{1'b0}};
            x_end_q       <= {X_WIDTH{1'b0}};
            y_end_q       <= {Y_WIDTH{1'b0}};
            empty_q       <= 1'b0;
            x_q           <= {X_WIDTH{1'b0}};
            y_q           <= {Y_WIDTH{1'b0}};
            color_q       <= {COLOR_WIDTH{1'b0}};
            abort_seen_q  <= 1'b0;
            pixel_write_q <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            setup_phase_q <= setup_phase_d;
            x_origin_q    <= x_origin_d;
            y_origin_q    <= y_origin_d;
            width_q       <= width_d;
            height_q      <= height_d;
            x_end_q       <= x_end_d;
            y_end_q       <= y_end_d;
            empty_q       <= empty_d;
            x_q           <= x_d;
            y_q           <= y_d;
            color_q       <= color_d;
            abort_seen_q  <= abort_seen_d;
            pixel_write_q <= pixel_write_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.pixelWrite = pixel_write_q;
    assign bus.xAddr      = x_q;
    assign bus.yAddr      = y_q;
    assign bus.pixelOut   = color_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Randomised self-checking bench for rect_draw_engine against a row-major
// rectangle model; honours DRAW_OUTLINE_EN the same way as the design.
module tb_rect_draw_engine;

    localparam int XW = 8;
    localparam int YW = 9;
    localparam int CW = 16;
    localparam int LW = 240;
    localparam int LH = 320;
`ifdef DRAW_OUTLINE_EN
    localparam bit OUTLINE_EN = 1'b1;
`else
    localparam bit OUTLINE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rect_draw_engine_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW)) bus ();

    rect_draw_engine #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW), .LCD_WIDTH(LW), .LCD_HEIGHT(LH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   oob_cnt = 0;
    int   pr_delay = 0;
    bit   abort_arm = 1'b0;
    int   abort_at = 0;
    pix_t got_q[$];
    pix_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Acceptance/done/range monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.pixelWrite && bus.pixelReady)
            got_q.push_back('{x: bus.xAddr, y: bus.yAddr, c: bus.pixelOut});
        if (bus.pixelWrite && ((int'(bus.xAddr) >= LW) || (int'(bus.yAddr) >= LH)))
            oob_cnt <= oob_cnt + 1;
        if (bus.done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    // Pixel-driver model: tied ready, random ready, or fixed wait per pixel (+ optional abort).
    initial begin
        int wcnt;
        wcnt = 0;
        bus.pixelReady = 1'b0;
        bus.abort = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.abort = 1'b0;
            if (pr_delay == 0) begin
                bus.pixelReady = 1'b1;
            end else if (pr_delay < 0) begin
                bus.pixelReady = 1'($urandom_range(0, 1));
            end else if (bus.pixelWrite) begin
                if (wcnt == pr_delay) begin
                    bus.pixelReady = 1'b1;
                    wcnt = 0;
                end else begin
                    bus.pixelReady = 1'b0;
                    if (abort_arm && (got_q.size() == abort_at) && (wcnt == 2)) bus.abort = 1'b1;
                    wcnt++;
                end
            end else begin
                bus.pixelReady = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Reference: every on-screen pixel of the rectangle, row-major, minus the interior in outline mode.
    task automatic build_expected(input int x0, input int y0, input int w, input int h,
                                  input bit ol, input logic [CW-1:0] col);
        int xl, yl;
        exp_q.delete();
        if (w == 0 || h == 0 || x0 >= LW || y0 >= LH) return;
        xl = (x0 + w - 1 < LW - 1) ? x0 + w - 1 : LW - 1;
        yl = (y0 + h - 1 < LH - 1) ? y0 + h - 1 : LH - 1;
        for (int y = y0; y <= yl; y++)
            for (int x = x0; x <= xl; x++)
                if (!(OUTLINE_EN && ol && y != y0 && y != yl && x != x0 && x != xl))
                    exp_q.push_back('{x: XW'(x), y: YW'(y), c: col});
    endtask

    task automatic scramble_inputs();
        bus.xOrigin   = XW'($urandom);
        bus.yOrigin   = YW'($urandom);
        bus.width     = XW'($urandom);
        bus.height    = YW'($urandom);
        bus.outline   = 1'($urandom);
        bus.pixelData = CW'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 1000) begin
            @(posedge clock); #1; n++;
        end
        check_eq(tag, 32'(bus.ready), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input int x0, input int y0, input int w, input int h,
                           input bit ol, input logic [CW-1:0] col, input int keep);
        int base, dbase, oob0, draw_cyc, n, n_exp;
        build_expected(x0, y0, w, h, ol, col);
        wait_ready({tag, "_ready_in"});
        base  = got_q.size();
        dbase = done_cnt;
        oob0  = oob_cnt;
        bus.xOrigin = XW'(x0); bus.yOrigin = YW'(y0);
        bus.width = XW'(w);    bus.height = YW'(h);
        bus.outline = ol;      bus.pixelData = col;
        bus.draw = 1'b1;
        @(posedge clock); #1;
        draw_cyc = cyc;
        bus.draw = 1'b0;
        scramble_inputs();
        n = 0;
        while (done_cnt == dbase && n < 5000) begin
            @(posedge clock); #1; n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt - dbase), 32'd1);
        check_eq({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        check_eq({tag, "_done_low"}, 32'(bus.done), 32'd0);
        n_exp = (keep >= 0) ? keep : exp_q.size();
        if (pr_delay == 0 && keep < 0)
            check_eq({tag, "_latency"}, 32'(last_done_cyc - draw_cyc),
                     (n_exp == 0) ? 32'd2 : 32'(2 + 2 * n_exp));
        repeat (2) begin @(posedge clock); #1; end
        check_eq({tag, "_done_once"}, 32'(done_cnt - dbase), 32'd1);
        check_eq({tag, "_count"}, 32'(got_q.size() - base), 32'(n_exp));
        for (int i = 0; i < n_exp && (base + i) < got_q.size(); i++) begin
            check_eq({tag, "_x"}, 32'(got_q[base+i].x), 32'(exp_q[i].x));
            check_eq({tag, "_y"}, 32'(got_q[base+i].y), 32'(exp_q[i].y));
            check_eq({tag, "_col"}, 32'(got_q[base+i].c), 32'(exp_q[i].c));
        end
        check_eq({tag, "_in_range"}, 32'(oob_cnt - oob0), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.ready), 32'd1);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_pw"}, 32'(bus.pixelWrite), 32'd0);
        check_eq({tag, "_x"}, 32'(bus.xAddr), 32'd0);
        check_eq({tag, "_y"}, 32'(bus.yAddr), 32'd0);
        check_eq({tag, "_pix"}, 32'(bus.pixelOut), 32'd0);
    endtask

    initial begin
        int x0, y0, w, h, dbase, n;
        reset = 1'b1;
        bus.draw = 1'b0;
        bus.xOrigin = '0; bus.yOrigin = '0; bus.width = '0; bus.height = '0;
        bus.outline = 1'b0; bus.pixelData = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        pr_delay = 0;
        run_cmd("fill3x2", 10, 20, 3, 2, 1'b0, 16'hA5C3, -1);
        run_cmd("clip", 230, 315, 20, 10, 1'b0, 16'h1234, -1);
        run_cmd("outline4x3", 0, 0, 4, 3, 1'b1, 16'hF00F, -1);
        run_cmd("w0", 5, 5, 0, 3, 1'b0, 16'h0001, -1);
        run_cmd("h0", 5, 5, 3, 0, 1'b0, 16'h0002, -1);
        run_cmd("xoff", 240, 5, 3, 3, 1'b0, 16'h0003, -1);
        run_cmd("yoff", 5, 320, 3, 3, 1'b0, 16'h0004, -1);
        run_cmd("corner", 239, 319, 5, 5, 1'b1, 16'h0005, -1);
        run_cmd("col1_ol", 7, 3, 1, 4, 1'b1, 16'h0006, -1);
        run_cmd("row1_ol", 7, 3, 4, 1, 1'b1, 16'h0007, -1);

        pr_delay  = 5;
        abort_arm = 1'b1;
        abort_at  = got_q.size() + 1;
        run_cmd("abort", 5, 5, 4, 1, 1'b0, 16'hBEEF, 2);
        abort_arm = 1'b0;

        // Reset while a pixel request is outstanding.
        wait_ready("rstmid_ready_in");
        bus.xOrigin = 8'd20; bus.yOrigin = 9'd30; bus.width = 8'd5; bus.height = 9'd5;
        bus.outline = 1'b0; bus.pixelData = 16'h5555;
        bus.draw = 1'b1;
        @(posedge clock); #1;
        bus.draw = 1'b0;
        n = 0;
        while (!bus.pixelWrite && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check_eq("rstmid_pw_seen", 32'(bus.pixelWrite), 32'd1);
        reset = 1'b1;
        dbase = done_cnt;
        @(posedge clock); #1;
        check_reset_outputs("rstmid");
        reset = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        check_eq("rstmid_no_done", 32'(done_cnt - dbase), 32'd0);
        pr_delay = 0;
        run_cmd("after_rst", 3, 4, 2, 2, 1'b0, 16'h7E7E, -1);

        for (int i = 0; i < 30; i++) begin
            x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(225, 255)) : int'($urandom_range(0, 60));
            y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(305, 330)) : int'($urandom_range(0, 60));
            w  = int'($urandom_range(0, 10));
            h  = int'($urandom_range(0, 10));
            case ($urandom_range(0, 2))
                0:       pr_delay = 0;
                1:       pr_delay = -1;
                default: pr_delay = 2;
            endcase
            run_cmd("rand", x0, y0, w, h, 1'($urandom), CW'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
